// File: rtl/uart_tx_frame_gen.sv
// UART transmitter with run-time bit period, 1/2 stop bits, optional parity and a tx_done pulse.
// Frame parameters are shadowed at accept so the live inputs may change freely mid-frame.
module uart_tx_frame_gen #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESC_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stop2,
    input  logic [PRESC_W-1:0]    prescale,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                state_q, state_d;
    logic [PRESC_W-1:0]    baud_q, baud_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic                  stop_half_q, stop_half_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  stop2_q, stop2_d;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  baud_last;

    assign baud_last = (baud_q == presc_q - PRESC_W'(1));

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        idx_d       = idx_q;
        stop_half_d = stop_half_q;
        data_d      = data_q;
        par_en_d    = par_en_q;
        par_typ_d   = par_typ_q;
        stop2_d     = stop2_q;
        presc_d     = presc_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (data_valid) begin
                    data_d      = p_data;
                    par_en_d    = par_en;
                    par_typ_d   = par_typ;
                    stop2_d     = stop2;
                    presc_d     = (prescale == '0) ? PRESC_W'(1) : prescale;
                    baud_d      = '0;
                    idx_d       = '0;
                    stop_half_d = 1'b0;
                    state_d     = StStart;
                end
            end
            StStart: begin
                if (baud_last) begin
                    baud_d  = '0;
                    idx_d   = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + PRESC_W'(1);
                end
            end
            StData: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (idx_q == IdxLast) begin
                        state_d     = par_en_q ? StParity : StStop;
                        stop_half_d = 1'b0;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end else begin
                    baud_d = baud_q + PRESC_W'(1);
                end
            end
            StParity: begin
                if (baud_last) begin
                    baud_d      = '0;
                    stop_half_d = 1'b0;
                    state_d     = StStop;
                end else begin
                    baud_d = baud_q + PRESC_W'(1);
                end
            end
            StStop: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Two stop bits: run the bit period a second time before finishing.
                    if (stop2_q && !stop_half_q) begin
                        stop_half_d = 1'b1;
                    end else begin
                        stop_half_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = StIdle;
                    end
                end else begin
                    baud_d = baud_q + PRESC_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != StIdle);
        unique case (state_d)
            StIdle:   tx_d = 1'b1;
            StStart:  tx_d = 1'b0;
            StData:   tx_d = data_d[idx_d];
            StParity: tx_d = (^data_d) ^ par_typ_d;
            StStop:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            baud_q      <= '0;
            idx_q       <= '0;
            stop_half_q <= 1'b0;
            data_q      <= '0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            stop2_q     <= 1'b0;
            presc_q     <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            idx_q       <= idx_d;
            stop_half_q <= stop_half_d;
            data_q      <= data_d;
            par_en_q    <= par_en_d;
            par_typ_q   <= par_typ_d;
            stop2_q     <= stop2_d;
            presc_q     <= presc_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign tx_out  = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Directed bench for uart_tx_frame_gen: an 8-bit and a 5-bit instance share clock and frame inputs.
module tb_uart_tx_frame_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] p_data = 8'h00;
    logic       dv8 = 1'b0;
    logic       dv5 = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       stop2 = 1'b0;
    logic [5:0] prescale = 6'd1;
    logic       tx8, busy8, done8;
    logic       tx5, busy5, done5;

    int comps = 0;
    int errs  = 0;

    always #5 clk = ~clk;

    uart_tx_frame_gen #(.DATA_WIDTH(8), .PRESC_W(6)) dut8 (
        .clk(clk), .rst(rst), .p_data(p_data), .data_valid(dv8), .par_en(par_en),
        .par_typ(par_typ), .stop2(stop2), .prescale(prescale),
        .tx_out(tx8), .busy(busy8), .tx_done(done8)
    );

    uart_tx_frame_gen #(.DATA_WIDTH(5), .PRESC_W(6)) dut5 (
        .clk(clk), .rst(rst), .p_data(p_data[4:0]), .data_valid(dv5), .par_en(par_en),
        .par_typ(par_typ), .stop2(stop2), .prescale(prescale),
        .tx_out(tx5), .busy(busy5), .tx_done(done5)
    );

    // Starts a frame and records n cycles of the selected instance; sample 0 is the cycle after accept.
    task automatic run_frame(input bit w5, input logic [7:0] d, input logic pe, input logic pt,
                             input logic s2, input logic [5:0] ps, input int n,
                             output logic [127:0] txw, output int busy_len,
                             output int done_at, output int done_cnt);
        p_data = d; par_en = pe; par_typ = pt; stop2 = s2; prescale = ps;
        if (w5) dv5 = 1'b1; else dv8 = 1'b1;
        txw = '1; busy_len = 0; done_at = -1; done_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            txw[i] = w5 ? tx5 : tx8;
            if (w5 ? busy5 : busy8) busy_len++;
            if (w5 ? done5 : done8) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (i == 0) begin dv5 = 1'b0; dv8 = 1'b0; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        comps++;
        if (tx8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            errs++;
            $display("FAIL reset8: tx/busy/done=%b%b%b required 100", tx8, busy8, done8);
        end
        comps++;
        if (tx5 !== 1'b1 || busy5 !== 1'b0 || done5 !== 1'b0) begin
            errs++;
            $display("FAIL reset5: tx/busy/done=%b%b%b required 100", tx5, busy5, done5);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_even_parity();
        logic [127:0] w; int bl, da, dc;
        int exp_bits[$] = '{0, 1,0,1,0,0,1,0,1, 0, 1};
        run_frame(1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 6'd4, 50, w, bl, da, dc);
        for (int i = 0; i < 44; i++) begin
            comps++;
            if (w[i] !== exp_bits[i/4][0]) begin
                errs++;
                $display("FAIL even_tx[%0d]: got %b required %0d", i, w[i], exp_bits[i/4]);
            end
        end
        comps++;
        if (bl !== 44) begin errs++; $display("FAIL even_busy: got %0d required 44", bl); end
        comps++;
        if (da !== 44 || dc !== 1) begin
            errs++;
            $display("FAIL even_done: at %0d count %0d required at 44 count 1", da, dc);
        end
        comps++;
        if (w[44] !== 1'b1) begin errs++; $display("FAIL even_idle: got %b required 1", w[44]); end
    endtask

    task automatic test_odd_stop2();
        logic [127:0] w; int bl, da, dc;
        int exp_bits[$] = '{0, 1,0,1,0,0,1,0,1, 1, 1, 1};
        run_frame(1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 6'd4, 52, w, bl, da, dc);
        for (int i = 0; i < 48; i++) begin
            comps++;
            if (w[i] !== exp_bits[i/4][0]) begin
                errs++;
                $display("FAIL odd_tx[%0d]: got %b required %0d", i, w[i], exp_bits[i/4]);
            end
        end
        comps++;
        if (bl !== 48) begin errs++; $display("FAIL odd_busy: got %0d required 48", bl); end
        comps++;
        if (da !== 48 || dc !== 1) begin
            errs++;
            $display("FAIL odd_done: at %0d count %0d required at 48 count 1", da, dc);
        end
    endtask

    task automatic test_presc_zero();
        logic [127:0] w; int bl, da, dc;
        int exp_bits[$] = '{0, 0,0,0,0,0,0,0,0, 1};
        run_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'd0, 14, w, bl, da, dc);
        for (int i = 0; i < 10; i++) begin
            comps++;
            if (w[i] !== exp_bits[i][0]) begin
                errs++;
                $display("FAIL p0_tx[%0d]: got %b required %0d", i, w[i], exp_bits[i]);
            end
        end
        comps++;
        if (bl !== 10) begin errs++; $display("FAIL p0_busy: got %0d required 10", bl); end
        comps++;
        if (da !== 10 || dc !== 1) begin
            errs++;
            $display("FAIL p0_done: at %0d count %0d required at 10 count 1", da, dc);
        end
    endtask

    task automatic test_back_to_back();
        int s1[$] = '{0, 0,0,1,1,1,1,0,0, 1};
        int s2[$] = '{0, 1,1,0,0,0,0,1,1, 1};
        int exp;
        int dcnt = 0;
        p_data = 8'h3C; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; prescale = 6'd2;
        dv8 = 1'b1;
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            if (i < 20) exp = s1[i/2];
            else if (i == 20 || i > 40) exp = 1;
            else exp = s2[(i-21)/2];
            comps++;
            if (tx8 !== exp[0]) begin
                errs++;
                $display("FAIL b2b_tx[%0d]: got %b required %0d", i, tx8, exp);
            end
            if (done8) dcnt++;
            if (i == 20 || i == 41) begin
                comps++;
                if (done8 !== 1'b1 || busy8 !== 1'b0) begin
                    errs++;
                    $display("FAIL b2b_done[%0d]: done/busy=%b%b required 10", i, done8, busy8);
                end
            end
            if (i == 5) begin p_data = 8'hFF; prescale = 6'd5; end
            if (i == 20) begin p_data = 8'hC3; prescale = 6'd2; end
            if (i == 21) dv8 = 1'b0;
        end
        comps++;
        if (dcnt !== 2) begin errs++; $display("FAIL b2b_done_cnt: got %0d required 2", dcnt); end
    endtask

    task automatic test_reset_mid_frame();
        logic [127:0] w; int bl, da, dc;
        int exp_bits[$] = '{0, 0,1,0,1,1,0,1,0, 1};
        int bad = 0;
        p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; prescale = 6'd4;
        dv8 = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 0) dv8 = 1'b0;
            if (i == 17) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        comps++;
        if (tx8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            errs++;
            $display("FAIL rst_mid: tx/busy/done=%b%b%b required 100", tx8, busy8, done8);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (tx8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) bad++;
        end
        comps++;
        if (bad !== 0) begin errs++; $display("FAIL rst_quiet: %0d bad cycles required 0", bad); end
        run_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 6'd1, 14, w, bl, da, dc);
        for (int i = 0; i < 10; i++) begin
            comps++;
            if (w[i] !== exp_bits[i][0]) begin
                errs++;
                $display("FAIL rst_new_tx[%0d]: got %b required %0d", i, w[i], exp_bits[i]);
            end
        end
        comps++;
        if (bl !== 10 || da !== 10) begin
            errs++;
            $display("FAIL rst_new_len: busy %0d done %0d required 10 and 10", bl, da);
        end
    endtask

    task automatic test_width5();
        logic [127:0] w; int bl, da, dc;
        int exp_bits[$] = '{0, 1,0,1,0,1, 0, 1};
        run_frame(1'b1, 8'h15, 1'b1, 1'b1, 1'b0, 6'd2, 20, w, bl, da, dc);
        for (int i = 0; i < 16; i++) begin
            comps++;
            if (w[i] !== exp_bits[i/2][0]) begin
                errs++;
                $display("FAIL w5_tx[%0d]: got %b required %0d", i, w[i], exp_bits[i/2]);
            end
        end
        comps++;
        if (bl !== 16) begin errs++; $display("FAIL w5_busy: got %0d required 16", bl); end
        comps++;
        if (da !== 16 || dc !== 1) begin
            errs++;
            $display("FAIL w5_done: at %0d count %0d required at 16 count 1", da, dc);
        end
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_stop2();
        test_presc_zero();
        test_back_to_back();
        test_reset_mid_frame();
        test_width5();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
        $finish;
    end

endmodule
